// File: rtl/tft_spi_pkg.sv
// Shared definitions for the TFT SPI link.
//   WORD_W_DEFAULT : default bits per SPI word
//   state_e        : receiver FSM encoding (IDLE, SHIFT)
//   DC_CMD/DC_DATA : data/command flag encoding
package tft_spi_pkg;

    localparam int unsigned WORD_W_DEFAULT = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

endpackage

// File: rtl/tft_spi_rx_fifo.sv
// Synchronous show-ahead FIFO for received SPI words.
//   clk, rst_n      : clock, asynchronous active-low reset
//   wr_en, wr_data  : push; accepted when not full, or when full with a read in the same cycle
//   full            : all DEPTH entries occupied
//   rd_en           : pop the head entry (ignored when empty)
//   rd_data         : head entry, combinational; holds the last popped entry while empty
//   empty           : no entries stored
module tft_spi_rx_fifo #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_idx, rd_idx, last_idx;
    logic             do_wr, do_rd;

    assign wr_idx   = wr_ptr_q[AW-1:0];
    assign rd_idx   = rd_ptr_q[AW-1:0];
    assign last_idx = rd_idx - AW'(1);

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);

    assign do_rd = rd_en && !empty;
    // When full, a concurrent read frees the head slot, which is the slot being written.
    assign do_wr = wr_en && (!full || do_rd);

    // The slot behind the read pointer still holds the last popped word while empty.
    assign rd_data = empty ? mem_q[last_idx] : mem_q[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem_q[wr_idx] <= wr_data;
                wr_ptr_q      <= wr_ptr_q + (AW + 1)'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/tft_spi_rx.sv
// SPI slave receiver for the TFT_SPI link, oversampled in the MasterCLK domain.
//   MasterCLK, MasterRST_n : system clock, asynchronous active-low reset
//   SPI_CLK, SPI_MOSI      : serial clock (idle low, sample on rise) and MSB-first data
//   SPI_CS_n, SPI_DC       : active-low frame select, data(1)/command(0) flag
//   data_o, dc_o, valid_o  : head-of-FIFO word, its DC flag, FIFO non-empty
//   ready_i                : consumer pops the head when valid_o && ready_i
//   frame_err_o            : one-cycle pulse when CS rises mid-word
//   overrun_o, clr_i       : sticky dropped-word flag and its synchronous clear
// WORD_W must be at least 3.
module tft_spi_rx
    import tft_spi_pkg::*;
#(
    parameter int unsigned WORD_W     = WORD_W_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              MasterCLK,
    input  logic              MasterRST_n,
    input  logic              SPI_CLK,
    input  logic              SPI_MOSI,
    input  logic              SPI_CS_n,
    input  logic              SPI_DC,
    output logic [WORD_W-1:0] data_o,
    output logic              dc_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              frame_err_o,
    output logic              overrun_o,
    input  logic              clr_i
);

    localparam int unsigned CNT_W = $clog2(WORD_W);

    // Synchronisers: SPI_CLK gets a third stage for edge detection; the rest line up with s2.
    logic [2:0] sclk_q;
    logic [1:0] mosi_q, dc_q, cs_q;
    logic       rise, mosi_s, dc_s, cs_s;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-2:0] shreg_q, shreg_d;
    logic              word_done, frame_err_d;

    logic              wr_en_q;
    logic [WORD_W:0]   wr_data_q;
    logic              frame_err_q, overrun_q;
    logic              fifo_full, fifo_empty, rd_en;
    logic [WORD_W:0]   rd_data;

    assign rise   = sclk_q[1] & ~sclk_q[2];
    assign mosi_s = mosi_q[1];
    assign dc_s   = dc_q[1];
    assign cs_s   = cs_q[1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        word_done   = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!cs_s) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // CS deassertion wins over a coincident clock rise.
                if (cs_s) begin
                    frame_err_d = (cnt_q != '0);
                    cnt_d       = '0;
                    state_d     = IDLE;
                end else if (rise) begin
                    shreg_d   = {shreg_q[WORD_W-3:0], mosi_s};
                    word_done = (cnt_q == CNT_W'(WORD_W - 1));
                    cnt_d     = word_done ? '0 : cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge MasterCLK or negedge MasterRST_n) begin
        if (!MasterRST_n) begin
            sclk_q      <= '0;
            mosi_q      <= '0;
            dc_q        <= '0;
            cs_q        <= '1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sclk_q      <= {sclk_q[1:0], SPI_CLK};
            mosi_q      <= {mosi_q[0], SPI_MOSI};
            dc_q        <= {dc_q[0], SPI_DC};
            cs_q        <= {cs_q[0], SPI_CS_n};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            wr_en_q     <= word_done;
            frame_err_q <= frame_err_d;
            if (word_done) begin
                wr_data_q <= {dc_s, shreg_q, mosi_s};
            end
            // A fresh overrun beats a coincident clear.
            if (wr_en_q && fifo_full && !rd_en) begin
                overrun_q <= 1'b1;
            end else if (clr_i) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign rd_en = valid_o && ready_i;

    tft_spi_rx_fifo #(
        .WIDTH (WORD_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (MasterCLK),
        .rst_n   (MasterRST_n),
        .wr_en   (wr_en_q),
        .wr_data (wr_data_q),
        .full    (fifo_full),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (fifo_empty)
    );

    assign valid_o     = !fifo_empty;
    assign dc_o        = rd_data[WORD_W];
    assign data_o      = rd_data[WORD_W-1:0];
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_tft_spi_rx.sv
// Directed bench for tft_spi_rx: inputs change 1 ns after a MasterCLK rise,
// outputs are observed on the falling edge.
module tb_tft_spi_rx;

    logic        MasterCLK, MasterRST_n;
    logic        SPI_CLK, SPI_MOSI, SPI_CS_n, SPI_DC;
    logic [15:0] data_o;
    logic        dc_o, valid_o, ready_i, frame_err_o, overrun_o, clr_i;

    int          n_checks = 0;
    int          n_errors = 0;
    int          err_cycles = 0;
    logic [16:0] beats[$];

    tft_spi_rx #(
        .WORD_W     (16),
        .FIFO_DEPTH (4)
    ) dut (
        .MasterCLK   (MasterCLK),
        .MasterRST_n (MasterRST_n),
        .SPI_CLK     (SPI_CLK),
        .SPI_MOSI    (SPI_MOSI),
        .SPI_CS_n    (SPI_CS_n),
        .SPI_DC      (SPI_DC),
        .data_o      (data_o),
        .dc_o        (dc_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .clr_i       (clr_i)
    );

    initial MasterCLK = 1'b0;
    always #5 MasterCLK = ~MasterCLK;

    // Record every accepted beat as {dc, data} and count frame-error cycles.
    always @(negedge MasterCLK) begin
        if (MasterRST_n) begin
            if (valid_o && ready_i) beats.push_back({dc_o, data_o});
            if (frame_err_o) err_cycles++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_beat(input string tag, input int idx, input logic [16:0] exp);
        check_eq(tag, (idx < beats.size()) ? {15'd0, beats[idx]} : 32'hxxxx_xxxx, {15'd0, exp});
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge MasterCLK);
            #1;
        end
    endtask

    // SPI_CLK = MasterCLK/8. With pulse_rd, ready_i is raised for exactly the
    // cycle in which the final word is written into the FIFO.
    task automatic send_bits(input logic [15:0] w, input logic dc, input int nbits,
                             input bit pulse_rd);
        SPI_DC = dc;
        for (int i = 0; i < nbits; i++) begin
            SPI_MOSI = w[15-i];
            tick(4);
            SPI_CLK = 1'b1;
            for (int k = 1; k <= 4; k++) begin
                tick(1);
                if (pulse_rd && i == nbits - 1) begin
                    if (k == 3) ready_i = 1'b1;
                    if (k == 4) ready_i = 1'b0;
                end
            end
            SPI_CLK = 1'b0;
        end
    endtask

    task automatic frame_start();
        SPI_CS_n = 1'b0;
        tick(4);
    endtask

    task automatic frame_end();
        tick(4);
        SPI_CS_n = 1'b1;
        tick(12);
    endtask

    initial begin
        MasterRST_n = 1'b0;
        SPI_CLK     = 1'b0;
        SPI_MOSI    = 1'b0;
        SPI_CS_n    = 1'b1;
        SPI_DC      = 1'b0;
        ready_i     = 1'b0;
        clr_i       = 1'b0;
        tick(3);
        check_eq("rst_valid", valid_o, 0);
        check_eq("rst_data", data_o, 0);
        check_eq("rst_dc", dc_o, 0);
        check_eq("rst_ferr", frame_err_o, 0);
        check_eq("rst_ovr", overrun_o, 0);
        MasterRST_n = 1'b1;
        tick(2);

        // Single word
        ready_i = 1'b1;
        frame_start();
        send_bits(16'hA5C3, 1'b1, 16, 1'b0);
        frame_end();
        check_eq("single_cnt", beats.size(), 1);
        check_beat("single_word", 0, 17'h1A5C3);
        check_eq("single_ferr", err_cycles, 0);
        check_eq("single_hold", data_o, 16'hA5C3);
        beats.delete();

        // Back-to-back words in one frame
        frame_start();
        send_bits(16'h002A, 1'b0, 16, 1'b0);
        send_bits(16'hFFFF, 1'b1, 16, 1'b0);
        frame_end();
        check_eq("b2b_cnt", beats.size(), 2);
        check_beat("b2b_w0", 0, 17'h0002A);
        check_beat("b2b_w1", 1, 17'h1FFFF);
        beats.delete();

        // Frame error after 9 bits, then a clean word
        frame_start();
        send_bits(16'hFFFF, 1'b1, 9, 1'b0);
        frame_end();
        check_eq("ferr_cycles", err_cycles, 1);
        check_eq("ferr_nowrite", beats.size(), 0);
        frame_start();
        send_bits(16'h1234, 1'b1, 16, 1'b0);
        frame_end();
        check_eq("ferr_next_cnt", beats.size(), 1);
        check_beat("ferr_next", 0, 17'h11234);
        check_eq("ferr_no_more", err_cycles, 1);
        beats.delete();

        // Overrun: five words into a four-deep FIFO with no reads
        ready_i = 1'b0;
        frame_start();
        for (int i = 1; i <= 5; i++) send_bits(16'(i), 1'b0, 16, 1'b0);
        frame_end();
        check_eq("ovr_flag", overrun_o, 1);
        check_eq("ovr_valid", valid_o, 1);
        check_eq("ovr_head", data_o, 16'h0001);
        ready_i = 1'b1;
        tick(10);
        check_eq("ovr_drain_cnt", beats.size(), 4);
        for (int i = 0; i < 4; i++) check_beat("ovr_drain", i, 17'(i + 1));
        check_eq("ovr_empty", valid_o, 0);
        check_eq("ovr_hold", data_o, 16'h0004);
        check_eq("ovr_sticky", overrun_o, 1);
        clr_i = 1'b1;
        tick(1);
        clr_i = 1'b0;
        check_eq("ovr_clr", overrun_o, 0);
        beats.delete();

        // Full FIFO with a read in the same cycle as the fifth write
        ready_i = 1'b0;
        frame_start();
        for (int i = 0; i < 4; i++) send_bits(16'h0011 + 16'(i), 1'b0, 16, 1'b0);
        send_bits(16'h0015, 1'b0, 16, 1'b1);
        frame_end();
        check_eq("full_rw_ovr", overrun_o, 0);
        check_eq("full_rw_one", beats.size(), 1);
        ready_i = 1'b1;
        tick(10);
        check_eq("full_rw_cnt", beats.size(), 5);
        for (int i = 0; i < 5; i++) check_beat("full_rw_order", i, 17'h00011 + 17'(i));
        beats.delete();

        // Reset mid-word with a word pending in the FIFO
        ready_i    = 1'b0;
        err_cycles = 0;
        frame_start();
        send_bits(16'h0777, 1'b1, 16, 1'b0);
        send_bits(16'hFFFF, 1'b1, 7, 1'b0);
        check_eq("prerst_valid", valid_o, 1);
        MasterRST_n = 1'b0;
        #1;
        check_eq("midrst_valid", valid_o, 0);
        check_eq("midrst_data", data_o, 0);
        check_eq("midrst_dc", dc_o, 0);
        SPI_CS_n = 1'b1;
        SPI_CLK  = 1'b0;
        tick(3);
        MasterRST_n = 1'b1;
        tick(2);
        ready_i = 1'b1;
        frame_start();
        send_bits(16'hBEEF, 1'b1, 16, 1'b0);
        frame_end();
        check_eq("postrst_cnt", beats.size(), 1);
        check_beat("postrst_word", 0, 17'h1BEEF);
        check_eq("postrst_ferr", err_cycles, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
